// File: rtl/cluster_pkg.sv
// Shared types and constants for the core dispatch cluster: FSM state encoding,
// reduction operator codes and default parameter values.
package cluster_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } cluster_state_t;

    localparam int RED_SUM = 0;
    localparam int RED_XOR = 1;
    localparam int RED_MAX = 2;

    localparam int DEFAULT_NUM_CORES = 9;
    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_RED_OP    = RED_SUM;
    localparam int DEFAULT_TIMEOUT   = 64;

endpackage

// File: rtl/cluster_reduce_unit.sv
// Combinational fold of the running accumulator with every response selected by
// take; cores are folded in ascending index order.
module cluster_reduce_unit
    import cluster_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int RED_OP    = DEFAULT_RED_OP
) (
    input  logic [DATA_W-1:0]           acc,
    input  logic [NUM_CORES-1:0]        take,
    input  logic [NUM_CORES*DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0]           acc_next
);

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (take[i]) begin
                if (RED_OP == RED_XOR) begin
                    acc_next = acc_next ^ rsp_data[i*DATA_W +: DATA_W];
                end else if (RED_OP == RED_MAX) begin
                    if (rsp_data[i*DATA_W +: DATA_W] > acc_next) begin
                        acc_next = rsp_data[i*DATA_W +: DATA_W];
                    end
                end else begin
                    // Sum wraps silently at DATA_W bits.
                    acc_next = acc_next + rsp_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/core_dispatch_cluster.sv
// Broadcasts one instruction to a masked set of cores, gathers one response per
// core into a reduction, and returns the result (partial on timeout or empty mask).
module core_dispatch_cluster
    import cluster_pkg::*;
#(
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int RED_OP    = DEFAULT_RED_OP,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends combinationally on the matching ready.
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    output logic                        instr_ready,
    input  logic [DATA_W-1:0]           instruction,
    input  logic [NUM_CORES-1:0]        core_en,
    output logic [NUM_CORES-1:0]        core_req_valid,
    input  logic [NUM_CORES-1:0]        core_req_ready,
    output logic [DATA_W-1:0]           core_instr,
    input  logic [NUM_CORES-1:0]        core_rsp_valid,
    input  logic [NUM_CORES*DATA_W-1:0] core_rsp_data,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [DATA_W-1:0]           result,
    output logic                        result_err,
    output logic                        busy,
    output logic [1:0]                  fsm_state
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    cluster_state_t         state;
    logic [DATA_W-1:0]      instr_q;
    logic [DATA_W-1:0]      acc;
    logic [DATA_W-1:0]      acc_next;
    logic [DATA_W-1:0]      result_q;
    logic                   err_q;
    logic [NUM_CORES-1:0]   active_mask;
    logic [NUM_CORES-1:0]   issued;
    logic [NUM_CORES-1:0]   received;
    logic [NUM_CORES-1:0]   req_fire;
    logic [NUM_CORES-1:0]   capture;
    logic [NUM_CORES-1:0]   issued_next;
    logic [NUM_CORES-1:0]   received_next;
    logic [15:0]            timer;
    logic                   in_flight;
    logic                   all_issued;
    logic                   all_received;
    logic                   timed_out;

    assign in_flight = (state == ST_ISSUE) || (state == ST_COLLECT);

    assign core_req_valid = (state == ST_ISSUE && !rst) ? (active_mask & ~issued) : '0;
    assign req_fire       = core_req_valid & core_req_ready;

    // Only a core whose request was accepted in an earlier cycle may answer, once.
    assign capture       = in_flight ? (core_rsp_valid & issued & ~received) : '0;
    assign issued_next   = issued | req_fire;
    assign received_next = received | capture;
    assign all_issued    = (issued_next & active_mask) == active_mask;
    assign all_received  = received_next == active_mask;
    assign timed_out     = timer == TIMER_LAST;

    cluster_reduce_unit #(
        .DATA_W    (DATA_W),
        .NUM_CORES (NUM_CORES),
        .RED_OP    (RED_OP)
    ) u_reduce (
        .acc      (acc),
        .take     (capture),
        .rsp_data (core_rsp_data),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            instr_q     <= '0;
            active_mask <= '0;
            issued      <= '0;
            received    <= '0;
            acc         <= '0;
            timer       <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instruction;
                        active_mask <= core_en;
                        issued      <= '0;
                        received    <= '0;
                        acc         <= '0;
                        timer       <= '0;
                        if (core_en == '0) begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE, ST_COLLECT: begin
                    issued   <= issued_next;
                    received <= received_next;
                    acc      <= acc_next;
                    timer    <= timer + 16'd1;
                    // Completion wins over a timeout landing in the same cycle.
                    if (all_received) begin
                        result_q <= acc_next;
                        err_q    <= 1'b0;
                        state    <= ST_DONE;
                    end else if (timed_out) begin
                        result_q <= acc_next;
                        err_q    <= 1'b1;
                        state    <= ST_DONE;
                    end else if (state == ST_ISSUE && all_issued) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready  = (state == ST_IDLE) && !rst;
    assign result_valid = (state == ST_DONE) && !rst;
    assign busy         = (state != ST_IDLE) && !rst;
    assign result       = rst ? '0 : result_q;
    assign result_err   = rst ? 1'b0 : err_q;
    assign core_instr   = rst ? '0 : instr_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_core_dispatch_cluster.sv
// Bench for core_dispatch_cluster: three instances (sum, xor, max) share one
// stimulus stream; a transaction-level model predicts result, error and latency.
`timescale 1ns/1ps
module tb_core_dispatch_cluster;

    localparam int NC    = 9;
    localparam int DW    = 32;
    localparam int TO    = 16;
    localparam int NEVER = 1000000;

    typedef struct packed {
        logic [31:0] sum;
        logic [31:0] xr;
        logic [31:0] mx;
        logic        err;
        logic [31:0] done_k;
    } exp_t;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic              instr_valid;
    logic [DW-1:0]     instruction;
    logic [NC-1:0]     core_en;
    logic [NC-1:0]     core_req_ready;
    logic [NC-1:0]     core_rsp_valid;
    logic [NC*DW-1:0]  core_rsp_data;
    logic              result_ready;

    logic [2:0]        instr_ready;
    logic [2:0]        result_valid;
    logic [2:0]        result_err;
    logic [2:0]        busy;
    logic [NC-1:0]     req_valid [3];
    logic [DW-1:0]     core_instr [3];
    logic [DW-1:0]     result [3];
    logic [1:0]        fsm_state [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        core_dispatch_cluster #(
            .NUM_CORES (NC),
            .DATA_W    (DW),
            .RED_OP    (g),
            .TIMEOUT   (TO)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .instr_valid    (instr_valid),
            .instr_ready    (instr_ready[g]),
            .instruction    (instruction),
            .core_en        (core_en),
            .core_req_valid (req_valid[g]),
            .core_req_ready (core_req_ready),
            .core_instr     (core_instr[g]),
            .core_rsp_valid (core_rsp_valid),
            .core_rsp_data  (core_rsp_data),
            .result_valid   (result_valid[g]),
            .result_ready   (result_ready),
            .result         (result[g]),
            .result_err     (result_err[g]),
            .busy           (busy[g]),
            .fsm_state      (fsm_state[g])
        );
    end

    // ---------------- bookkeeping ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   done_cnt = 0;
    int   bp_left  = 0;

    // Next transaction description (set by the test sequence).
    logic [NC-1:0] nx_en;
    int            nx_rdel [NC];
    int            nx_rsp  [NC];
    logic [DW-1:0] nx_val  [NC];
    int            nx_dup  [NC];
    // Transaction currently owned by the cores.
    logic [NC-1:0] cur_en;
    int            cur_rdel [NC];
    int            cur_rsp  [NC];
    logic [DW-1:0] cur_val  [NC];
    int            cur_dup  [NC];
    int            cur_t0;
    logic [DW-1:0] cur_instr;
    bit            txn_live = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Cycle (relative to accept = 0) at which core i's response strobe appears.
    function automatic int rsp_cycle(input int rdel, input int rsp);
        return (rsp >= NEVER) ? NEVER : 1 + rdel + 1 + rsp;
    endfunction

    // Reference model: responses landing within the TO-cycle window are folded;
    // the transaction ends one cycle after the last response, or after TO cycles.
    function automatic exp_t model();
        exp_t e;
        bit   all_in;
        int   last;
        int   rc;
        e      = '0;
        all_in = 1'b1;
        last   = 0;
        for (int i = 0; i < NC; i++) begin
            if (nx_en[i]) begin
                rc = rsp_cycle(nx_rdel[i], nx_rsp[i]);
                if (rc <= TO) begin
                    e.sum = e.sum + nx_val[i];
                    e.xr  = e.xr ^ nx_val[i];
                    if (nx_val[i] > e.mx) e.mx = nx_val[i];
                    if (rc > last) last = rc;
                end else begin
                    all_in = 1'b0;
                end
            end
        end
        if (nx_en == '0) begin
            e.err = 1'b1; e.done_k = 32'd1;
        end else if (all_in) begin
            e.err = 1'b0; e.done_k = 32'(last + 1);
        end else begin
            e.err = 1'b1; e.done_k = 32'(TO + 1);
        end
        return e;
    endfunction

    // ---------------- core and consumer behaviour ----------------
    initial begin
        core_req_ready = '0;
        core_rsp_valid = '0;
        core_rsp_data  = '0;
        result_ready   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NC; i++) begin
                core_rsp_data[i*DW +: DW] = $urandom;
                if (txn_live && cur_en[i]) begin
                    int k;
                    int rc;
                    k  = cyc - cur_t0;
                    rc = rsp_cycle(cur_rdel[i], cur_rsp[i]);
                    core_req_ready[i] = (k >= 1 + cur_rdel[i]);
                    if (k == rc) begin
                        core_rsp_valid[i] = 1'b1;
                        core_rsp_data[i*DW +: DW] = cur_val[i];
                    end else if (cur_dup[i] != 0 && k == rc + cur_dup[i]) begin
                        core_rsp_valid[i] = 1'b1;
                        core_rsp_data[i*DW +: DW] = ~cur_val[i];
                    end else begin
                        core_rsp_valid[i] = 1'b0;
                    end
                end else begin
                    core_req_ready[i] = 1'($urandom_range(0, 1));
                    core_rsp_valid[i] = ($urandom_range(0, 7) == 0);
                end
            end
            if (result_valid[0]) begin
                if (bp_left > 0) begin
                    result_ready = 1'b0;
                    bp_left--;
                end else begin
                    result_ready = ($urandom_range(0, 3) != 0);
                end
            end else begin
                result_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_default(input logic [DW-1:0] v);
        nx_en = '1;
        for (int i = 0; i < NC; i++) begin
            nx_rdel[i] = 0; nx_rsp[i] = 0; nx_val[i] = v; nx_dup[i] = 0;
        end
    endtask

    task automatic start_txn();
        int w = 0;
        @(posedge clk);
        #1;
        instruction = $urandom;
        core_en     = nx_en;
        instr_valid = 1'b1;
        while (!instr_ready[0] && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("accept", 64'(instr_ready[0]), 64'd1);
        if (instr_ready[0]) begin
            cur_en    = nx_en;
            cur_rdel  = nx_rdel;
            cur_rsp   = nx_rsp;
            cur_val   = nx_val;
            cur_dup   = nx_dup;
            cur_t0    = cyc;
            cur_instr = instruction;
            txn_live  = 1'b1;
            exp_q.push_back(model());
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instruction = $urandom;
        core_en     = NC'($urandom);
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int w = 0;
        while (done_cnt == start && w < 200) begin
            @(posedge clk);
            w++;
        end
        check("result_handshake_seen", 64'(done_cnt != start), 64'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t cur_e;
    bit   have_e = 1'b0;

    always @(negedge clk) begin : mon
        int            k;
        logic          any;
        logic [NC-1:0] exp_rv;
        if (rst) begin
            have_e = 1'b0;
            any = 1'b0;
            for (int g = 0; g < 3; g++) begin
                any = any | (req_valid[g] != '0) | (core_instr[g] != '0) | (result[g] != '0);
            end
            check("reset_outputs", 64'({any, instr_ready, result_valid, result_err, busy}), 64'd0);
        end else begin
            k = cyc - cur_t0;
            for (int i = 0; i < NC; i++) begin
                exp_rv[i] = txn_live && cur_en[i] && (k >= 1) && (k <= 1 + cur_rdel[i]) && (k <= TO);
            end
            check("req_valid", 64'(req_valid[0]), 64'(exp_rv));
            check("valid_agree", 64'({result_valid[1], result_valid[2]}), 64'({2{result_valid[0]}}));
            if (result_valid[0]) begin
                check("instr_ready_in_done", 64'(instr_ready[0]), 64'd0);
                if (!have_e) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 64'(result_valid[0]), 64'd0);
                    end else begin
                        cur_e  = exp_q.pop_front();
                        have_e = 1'b1;
                        check("latency", 64'(k), 64'(cur_e.done_k));
                        check("core_instr", 64'(core_instr[0]), 64'(cur_instr));
                    end
                end
                if (have_e) begin
                    check("sum", 64'(result[0]), 64'(cur_e.sum));
                    check("xor", 64'(result[1]), 64'(cur_e.xr));
                    check("max", 64'(result[2]), 64'(cur_e.mx));
                    check("err", 64'(result_err), 64'({3{cur_e.err}}));
                    if (result_ready) begin
                        have_e = 1'b0;
                        done_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        core_en     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Happy path: core i returns i+1 right after its handshake.
        set_default('0);
        for (int i = 0; i < NC; i++) nx_val[i] = DW'(i + 1);
        start_txn();
        wait_done();

        // XOR with staggered arrivals on cores 0 and 1.
        set_default('0);
        nx_val[0] = 32'hF0F0_0000; nx_rsp[0] = 3;
        nx_val[1] = 32'h0000_F0F0; nx_rsp[1] = 1; nx_rdel[1] = 2;
        for (int i = 2; i < NC; i++) begin
            nx_rdel[i] = $urandom_range(0, 2);
            nx_rsp[i]  = $urandom_range(0, 2);
        end
        start_txn();
        wait_done();

        // Timeout: core 8 stays silent.
        set_default(32'd1);
        nx_rsp[8] = NEVER;
        start_txn();
        wait_done();

        // Empty mask.
        set_default(32'd7);
        nx_en = '0;
        start_txn();
        wait_done();

        // Backpressure plus a duplicate response during COLLECT.
        set_default(32'd3);
        nx_rsp[0] = 4;
        nx_dup[3] = 1;
        nx_val[5] = 32'hFFFF_FFF0;
        bp_left = 5;
        start_txn();
        wait_done();

        // Reset while collecting; nothing may surface afterwards.
        set_default(32'd9);
        for (int i = 0; i < NC; i++) nx_rsp[i] = 6;
        start_txn();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        txn_live = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        set_default('0);
        for (int i = 0; i < NC; i++) nx_val[i] = DW'(i + 1);
        start_txn();
        wait_done();

        // Random transactions, including timeouts at the window edge.
        for (int t = 0; t < 40; t++) begin
            nx_en = NC'($urandom);
            if (t % 8 == 0) nx_en = '1;
            if (t % 13 == 5) nx_en = '0;
            for (int i = 0; i < NC; i++) begin
                nx_rdel[i] = $urandom_range(0, 6);
                nx_rsp[i]  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 8));
                nx_val[i]  = (t % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 255));
                nx_dup[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            bp_left = $urandom_range(0, 3);
            start_txn();
            wait_done();
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_dispatch_cluster.md
CORE_DISPATCH_CLUSTER -- requirements
Module: core_dispatch_cluster

Interface
REQ-001 Parameter NUM_CORES, default 9: number of attached cores; legal range 1..16.
REQ-002 Parameter DATA_W, default 32: instruction and data width.
REQ-003 Parameter RED_OP, default 0: reduction operator. 0 = sum modulo 2^DATA_W, 1 = XOR, 2 = unsigned max.
REQ-004 Parameter TIMEOUT, default 64: maximum number of cycles an instruction may spend in ISSUE plus COLLECT; legal range 2..65535.
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 instr_valid  in  1  an instruction is offered.
REQ-008 instr_ready  out  1  the cluster can accept an instruction.
REQ-009 instruction  in  DATA_W  the instruction word.
REQ-010 core_en  in  NUM_CORES  per-core enable mask, sampled only at accept.
REQ-011 core_req_valid  out  NUM_CORES  per-core request valid.
REQ-012 core_req_ready  in  NUM_CORES  per-core request ready.
REQ-013 core_instr  out  DATA_W  latched instruction; shared by all cores.
REQ-014 core_rsp_valid  in  NUM_CORES  per-core response strobe; one cycle per response.
REQ-015 core_rsp_data  in  NUM_CORES*DATA_W  per-core response; core i occupies bits [i*DATA_W +: DATA_W].
REQ-016 result_valid  out  1  the reduced result is available.
REQ-017 result_ready  in  1  the consumer accepts the result.
REQ-018 result  out  DATA_W  the reduced result.
REQ-019 result_err  out  1  the result is partial (timeout, or empty mask).
REQ-020 busy  out  1  the FSM is not in IDLE.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, COLLECT, DONE. At most one instruction is in flight.
REQ-022 IDLE behaviour:
- instr_ready=1 only in IDLE.
- When instr_valid&instr_ready, SHALL latch instruction into core_instr and core_en into active_mask.
- SHALL clear the issued mask, received mask, accumulator and timer.
- SHALL go to ISSUE, or to DONE with result=0 and result_err=1 if core_en==0.
REQ-023 ISSUE: core_req_valid[i] = active_mask[i] & ~issued[i]. issued[i] SHALL set on the cycle core_req_valid[i]&core_req_ready[i]. When all active cores are issued (including same-cycle handshakes), go to COLLECT.
REQ-024 Response capture, in ISSUE and COLLECT:
- core_rsp_valid[i] SHALL be captured only if issued[i] (registered value) & ~received[i].
- Other responses SHALL be ignored, including responses in IDLE or DONE and duplicate responses.
REQ-025 Several responses captured in the same cycle SHALL all be folded into the accumulator that cycle, in ascending core index order (order is irrelevant for the supported operators).
REQ-026 Accumulator initial values: 0 for sum, XOR and max. Sum wraps modulo 2^DATA_W with no overflow flag.
REQ-027 When received==active_mask, SHALL go to DONE with result_err=0. The last response's contribution SHALL be included in result.
REQ-028 Timer:
- Counts every cycle in ISSUE and COLLECT.
- When it reaches TIMEOUT-1 without completion, SHALL go to DONE with result_err=1 and result equal to the partial accumulator, including any responses captured that cycle.
- core_req_valid SHALL be 0 from the next cycle.
REQ-029 Completion and timeout in the same cycle SHALL resolve as completion (result_err=0).
REQ-030 DONE: result_valid=1, and result/result_err SHALL be held stable until result_ready. On the handshake, go to IDLE. The next instruction is accepted no earlier than the following cycle.
REQ-031 Minimum latency: accept at cycle 0, request handshake at cycle 1, response at cycle 2, result_valid at cycle 3.
REQ-032 core_req_valid and result_valid SHALL not depend combinationally on core_req_ready or result_ready.

Reset
REQ-033 On rst, the FSM SHALL enter IDLE and clear the issued, received, accumulator and timer registers.
REQ-034 Output values during reset:
- instr_ready=0.
- core_req_valid=0.
- result_valid=0, result=0, result_err=0.
- busy=0.
- core_instr=0.
REQ-035 A reset asserted mid-operation SHALL abandon the in-flight instruction without producing a result.
REQ-036 Responses arriving in the first cycle after reset SHALL be ignored.

Structure
REQ-037 Package cluster_pkg SHALL hold:
- the state enum;
- the RED_OP encodings RED_SUM, RED_XOR, RED_MAX;
- the default parameter constants.
REQ-038 A sub-module cluster_reduce_unit SHALL contain the combinational fold of the accumulator with NUM_CORES masked responses; it is parametrised by DATA_W, NUM_CORES and RED_OP.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Happy path, sum: NUM_CORES=9, all ready, core i returns i+1 the cycle after its handshake -> result=45, err=0, result_valid at cycle 3.
- XOR, staggered: RED_OP=1, core_en=0x1FF, responses 0xF0F0_0000 and 0x0000_F0F0 on cores 0/1 arriving over several cycles, all others 0 -> result=0xF0F0_F0F0.
- Timeout: core 8 never responds, TIMEOUT=16, the other cores return 1 -> result_valid after 16 cycles, result=8, err=1, core_req_valid=0.
- Empty mask: core_en=0 -> DONE the next cycle, result=0, err=1, no core_req_valid pulse.
- Backpressure: result_ready low for 5 cycles, plus a duplicate core response -> result held stable, duplicate ignored, instr_ready=0 until the handshake.
- Reset mid-COLLECT: assert rst -> result_valid is never seen, all outputs 0; a new instruction after reset completes correctly.
